m_uart_loader: RTL

UART program loader sitting directly upstream of the processor's instruction memory. It receives a length-prefixed program image over a serial line (8N1) and assembles big-endian 32-bit words. Each word is written sequentially into the 4K-word memory write port starting at word address 0. It holds the processor in reset until the image is complete; `r_done` drives the processor reset (`~r_done`).

---
 rtl/m_uart_loader.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/m_uart_loader.sv
// m_uart_loader: 8N1 receiver that loads a length-prefixed, big-endian word image into instruction memory.
// Optional LOADER_CHECKSUM_EN appends a trailing mod-2^32 sum word that must match the data words.
`default_nettype none

module m_uart_loader #(
  parameter int BAUD_DIV  = 868,
  parameter int MAX_WORDS = 4096
) (
  input  logic        w_clk,
  input  logic        w_rst_n,
  input  logic        w_rxd,
  output logic        r_we,
  output logic [11:0] r_addr,
  output logic [31:0] r_data,
  output logic        r_done,
  output logic        r_err
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_LEN, S_DATA, S_SUM, S_DONE, S_ERR} ld_state_t;
`else
  typedef enum logic [2:0] {S_LEN, S_DATA, S_DONE, S_ERR} ld_state_t;
`endif

  rx_state_t     rx_state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    rx_shift;
  logic          rxd_meta, rxd_sync, rxd_prev;

  // Stop-bit sample decisions are combinational so the loader registers its outputs one cycle later.
  logic sample_full, byte_valid, frame_err;
  assign sample_full = (baud_cnt == FULL_M1);
  assign byte_valid  = (rx_state == RX_STOP) && sample_full && rxd_sync;
  assign frame_err   = (rx_state == RX_STOP) && sample_full && !rxd_sync;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
      rx_state <= RX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      rx_shift <= '0;
    end else begin
      rxd_meta <= w_rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
      case (rx_state)
        RX_IDLE: begin
          baud_cnt <= '0;
          if (rxd_prev && !rxd_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (baud_cnt == HALF_M1) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            rx_state <= rxd_sync ? RX_IDLE : RX_BITS;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_BITS: begin
          if (sample_full) begin
            baud_cnt <= '0;
            rx_shift <= {rxd_sync, rx_shift[7:1]};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) rx_state <= RX_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (sample_full) begin
            baud_cnt <= '0;
            rx_state <= RX_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  ld_state_t   ld_state;
  logic [1:0]  byte_cnt;
  logic [23:0] word_hold;
  logic [12:0] idx;
  logic [12:0] len;
  logic [31:0] word_next;
  logic        word_valid;
  assign word_next  = {word_hold, rx_shift};
  assign word_valid = byte_valid && (byte_cnt == 2'd3);

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum;
`endif

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      ld_state  <= S_LEN;
      byte_cnt  <= '0;
      word_hold <= '0;
      idx       <= '0;
      len       <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      if (byte_valid) begin
        byte_cnt  <= byte_cnt + 1'b1;
        word_hold <= word_next[23:0];
      end
      if (frame_err && ld_state != S_DONE && ld_state != S_ERR) begin
        ld_state <= S_ERR;
        r_err    <= 1'b1;
      end else begin
        case (ld_state)
          S_LEN: if (word_valid) begin
            if (word_next == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
              ld_state <= S_SUM;
`else
              ld_state <= S_DONE;
              r_done   <= 1'b1;
`endif
            end else if (word_next > 32'(MAX_WORDS)) begin
              ld_state <= S_ERR;
              r_err    <= 1'b1;
            end else begin
              ld_state <= S_DATA;
              len      <= word_next[12:0];
            end
          end
          S_DATA: if (word_valid) begin
            r_we   <= 1'b1;
            r_addr <= idx[11:0];
            r_data <= word_next;
            idx    <= idx + 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum    <= sum + word_next;
            if (idx == len - 1'b1) ld_state <= S_SUM;
`else
            if (idx == len - 1'b1) ld_state <= S_DONE;
`endif
          end
`ifdef LOADER_CHECKSUM_EN
          S_SUM: if (word_valid) begin
            if (word_next == sum) begin
              ld_state <= S_DONE;
              r_done   <= 1'b1;
            end else begin
              ld_state <= S_ERR;
              r_err    <= 1'b1;
            end
          end
`endif
          S_DONE:  r_done <= 1'b1;
          S_ERR:   r_err  <= 1'b1;
          default: ld_state <= S_ERR;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
